// File: rtl/rob_pkg.sv
// Shared definitions for the multi-commit reorder buffer: entry type codes
// and small classification helpers used by dispatch and commit logic.
package rob_pkg;

    localparam int ROB_TYPE_W = 3;

    typedef enum logic [ROB_TYPE_W-1:0] {
        ROB_REG  = 3'd0,
        ROB_REGI = 3'd1,
        ROB_ST   = 3'd2,
        ROB_BR   = 3'd3,
        ROB_LD   = 3'd4,
        ROB_NOP  = 3'd5
    } rob_type_e;

    // Entry types that rename and later write back a destination register.
    function automatic logic rob_writes_reg(input logic [ROB_TYPE_W-1:0] t);
        return (t == ROB_REG) || (t == ROB_REGI);
    endfunction

    // Entry types that must retire alone in their commit cycle.
    function automatic logic rob_is_serial(input logic [ROB_TYPE_W-1:0] t);
        return (t == ROB_ST) || (t == ROB_BR);
    endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Commit selection for the two oldest ROB entries. Decides how many entries
// retire this cycle from registered state only, formats the register commit
// slots, raises the store-commit request and detects a branch mispredict.
module rob_commit_sel
    import rob_pkg::*;
#(
    parameter int IDX_W    = 5,
    parameter int COMMIT_W = 2
) (
    input  logic                      en,
    input  logic [IDX_W:0]            count,
    input  logic                      st_ack,
    input  logic [IDX_W-1:0]          head,
    input  logic [ROB_TYPE_W-1:0]     h0_type,
    input  logic                      h0_done,
    input  logic [4:0]                h0_rd,
    input  logic [31:0]               h0_value,
    input  logic [ROB_TYPE_W-1:0]     h1_type,
    input  logic                      h1_done,
    input  logic [4:0]                h1_rd,
    input  logic [31:0]               h1_value,
    output logic [1:0]                n_commit,
    output logic [COMMIT_W-1:0]       cm_valid,
    output logic [COMMIT_W*5-1:0]     cm_rd,
    output logic [COMMIT_W*IDX_W-1:0] cm_tag,
    output logic [COMMIT_W*32-1:0]    cm_value,
    output logic                      st_commit,
    output logic                      mispredict
);
    logic                 h0_live;
    logic                 h1_live;
    logic                 c0;
    logic                 c1;
    logic [1:0]           v2;
    logic [9:0]           rd2;
    logic [2*IDX_W-1:0]   tag2;
    logic [63:0]          val2;

    // Store handshake: st_commit is a valid-style request that stays high while
    // the head is a finished store; the store retires in the cycle st_ack is
    // seen together with st_commit, otherwise the head holds.

    // Retire decision for the head pair; the second slot only follows a
    // non-serial head and is itself non-serial, so at most one ST/BR retires.
    always_comb begin
        h0_live    = (count != '0);
        h1_live    = (count > (IDX_W+1)'(1));
        c0         = en && h0_live && h0_done && ((h0_type != ROB_ST) || st_ack);
        c1         = (COMMIT_W == 2) && c0 && h1_live && h1_done &&
                     !rob_is_serial(h0_type) && !rob_is_serial(h1_type);
        n_commit   = {1'b0, c0} + {1'b0, c1};
        st_commit  = en && h0_live && h0_done && (h0_type == ROB_ST);
        mispredict = c0 && (h0_type == ROB_BR) && (h0_value[0] != h0_rd[0]);
        v2         = {c1 && rob_writes_reg(h1_type), c0 && rob_writes_reg(h0_type)};
        rd2        = {v2[1] ? h1_rd : 5'd0, v2[0] ? h0_rd : 5'd0};
        tag2       = {v2[1] ? head + IDX_W'(1) : '0, v2[0] ? head : '0};
        val2       = {v2[1] ? h1_value : 32'd0, v2[0] ? h0_value : 32'd0};
    end

    assign cm_valid = v2[COMMIT_W-1:0];
    assign cm_rd    = rd2[COMMIT_W*5-1:0];
    assign cm_tag   = tag2[COMMIT_W*IDX_W-1:0];
    assign cm_value = val2[COMMIT_W*32-1:0];

endmodule

// File: rtl/rob_mc.sv
// Parametrised reorder buffer: in-order dispatch, N-channel writeback with
// operand bypass, up to two in-order retirements per cycle, store-commit
// handshake and a registered flush on branch mispredict.
module rob_mc
    import rob_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int IDX_W    = 5,
    parameter int WB_PORTS = 2,
    parameter int COMMIT_W = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    output logic                      full,
    output logic [IDX_W-1:0]          free_id,
    output logic [IDX_W-1:0]          head_id,
    output logic                      flush,
    output logic [31:0]               rst_addr,
    input  logic                      dsp_valid,
    input  logic [ROB_TYPE_W-1:0]     dsp_type,
    input  logic [4:0]                dsp_rd,
    input  logic [31:0]               dsp_value,
    input  logic [31:0]               dsp_addr,
    input  logic                      dsp_done,
    input  logic [2*IDX_W-1:0]        qry_id,
    output logic [1:0]                qry_ready,
    output logic [63:0]               qry_value,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0] wb_id,
    input  logic [WB_PORTS*32-1:0]    wb_value,
    output logic [COMMIT_W-1:0]       cm_valid,
    output logic [COMMIT_W*5-1:0]     cm_rd,
    output logic [COMMIT_W*IDX_W-1:0] cm_tag,
    output logic [COMMIT_W*32-1:0]    cm_value,
    output logic                      dep_valid,
    output logic [4:0]                dep_rd,
    output logic [IDX_W-1:0]          dep_tag,
    output logic                      st_commit,
    input  logic                      st_ack
);
    localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(DEPTH - 1);

    logic [ROB_TYPE_W-1:0] e_type  [DEPTH];
    logic [4:0]            e_rd    [DEPTH];
    logic [31:0]           e_value [DEPTH];
    logic [31:0]           e_addr  [DEPTH];
    logic [DEPTH-1:0]      e_done;

    logic [IDX_W-1:0]      head;
    logic [IDX_W-1:0]      tail;
    logic [IDX_W:0]        count;
    logic [IDX_W-1:0]      head_p1;
    logic [1:0]            n_commit;
    logic                  mispredict;
    logic                  active;
    logic                  dsp_fire;
    logic [WB_PORTS-1:0]   wb_fire;
    logic [IDX_W-1:0]      q_tag;

    // A flush cycle and a stalled clock both freeze every input-driven action.
    assign active   = rdy_in && !flush;
    assign head_p1  = head + IDX_W'(1);
    // A full buffer still accepts a dispatch when the head retires this cycle.
    assign dsp_fire = active && dsp_valid && ((count != CNT_FULL) || (n_commit != 2'd0));
    assign wb_fire  = wb_valid & {WB_PORTS{active}};

    assign full      = (count == CNT_FULL) ||
                       ((count == CNT_LAST) && dsp_valid && (n_commit == 2'd0));
    assign free_id   = tail + IDX_W'(dsp_fire);
    assign head_id   = head + IDX_W'(n_commit);
    assign dep_valid = dsp_fire && rob_writes_reg(dsp_type);
    assign dep_rd    = dsp_rd;
    assign dep_tag   = tail;

    rob_commit_sel #(
        .IDX_W    (IDX_W),
        .COMMIT_W (COMMIT_W)
    ) u_commit_sel (
        .en         (active),
        .count      (count),
        .st_ack     (st_ack),
        .head       (head),
        .h0_type    (e_type[head]),
        .h0_done    (e_done[head]),
        .h0_rd      (e_rd[head]),
        .h0_value   (e_value[head]),
        .h1_type    (e_type[head_p1]),
        .h1_done    (e_done[head_p1]),
        .h1_rd      (e_rd[head_p1]),
        .h1_value   (e_value[head_p1]),
        .n_commit   (n_commit),
        .cm_valid   (cm_valid),
        .cm_rd      (cm_rd),
        .cm_tag     (cm_tag),
        .cm_value   (cm_value),
        .st_commit  (st_commit),
        .mispredict (mispredict)
    );

    // Operand lookup: same-cycle dispatch beats writeback, which beats stored state.
    always_comb begin
        qry_ready = '0;
        qry_value = '0;
        q_tag     = '0;
        for (int q = 0; q < 2; q++) begin
            q_tag                 = qry_id[q*IDX_W +: IDX_W];
            qry_ready[q]          = e_done[q_tag];
            qry_value[q*32 +: 32] = e_value[q_tag];
            for (int k = 0; k < WB_PORTS; k++) begin
                if (wb_fire[k] && (wb_id[k*IDX_W +: IDX_W] == q_tag)) begin
                    qry_ready[q]          = 1'b1;
                    qry_value[q*32 +: 32] = wb_value[k*32 +: 32];
                end
            end
            if (dsp_fire && (tail == q_tag)) begin
                qry_ready[q]          = dsp_done;
                qry_value[q*32 +: 32] = dsp_value;
            end
        end
    end

    // Pointer, entry and flush state; a pending flush empties the buffer next edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            e_done   <= '0;
            flush    <= 1'b0;
            rst_addr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_type[i]  <= '0;
                e_rd[i]    <= '0;
                e_value[i] <= '0;
                e_addr[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (flush) begin
                head   <= '0;
                tail   <= '0;
                count  <= '0;
                e_done <= '0;
                flush  <= 1'b0;
            end else begin
                head  <= head + IDX_W'(n_commit);
                tail  <= tail + IDX_W'(dsp_fire);
                count <= count + (IDX_W+1)'(dsp_fire) - (IDX_W+1)'(n_commit);
                if (dsp_fire) begin
                    e_type[tail]  <= dsp_type;
                    e_rd[tail]    <= dsp_rd;
                    e_value[tail] <= dsp_value;
                    e_addr[tail]  <= dsp_addr;
                    e_done[tail]  <= dsp_done;
                end
                for (int k = 0; k < WB_PORTS; k++) begin
                    if (wb_valid[k]) begin
                        e_done[wb_id[k*IDX_W +: IDX_W]]  <= 1'b1;
                        e_value[wb_id[k*IDX_W +: IDX_W]] <= wb_value[k*32 +: 32];
                    end
                end
                if (mispredict) begin
                    flush    <= 1'b1;
                    rst_addr <= e_addr[head];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_mc.sv
// Self-checking bench for rob_mc: a queue-based model of the in-flight window
// is compared against every DUT output each cycle, under directed scenarios
// with hand-computed expectations followed by randomized traffic.
module tb_rob_mc;
    import rob_pkg::*;

    localparam int DEPTH = 32;
    localparam int IDX_W = 5;
    localparam int WB    = 2;
    localparam int CW    = 2;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               rdy_in;
    logic               full;
    logic [IDX_W-1:0]   free_id;
    logic [IDX_W-1:0]   head_id;
    logic               flush;
    logic [31:0]        rst_addr;
    logic               dsp_valid;
    logic [2:0]         dsp_type;
    logic [4:0]         dsp_rd;
    logic [31:0]        dsp_value;
    logic [31:0]        dsp_addr;
    logic               dsp_done;
    logic [2*IDX_W-1:0] qry_id;
    logic [1:0]         qry_ready;
    logic [63:0]        qry_value;
    logic [WB-1:0]      wb_valid;
    logic [WB*IDX_W-1:0] wb_id;
    logic [WB*32-1:0]   wb_value;
    logic [CW-1:0]      cm_valid;
    logic [CW*5-1:0]    cm_rd;
    logic [CW*IDX_W-1:0] cm_tag;
    logic [CW*32-1:0]   cm_value;
    logic               dep_valid;
    logic [4:0]         dep_rd;
    logic [IDX_W-1:0]   dep_tag;
    logic               st_commit;
    logic               st_ack;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: program-order queue of in-flight tags plus per-tag entry contents.
    logic [IDX_W-1:0] exp_q[$];
    logic [2:0]       m_type [DEPTH];
    logic [4:0]       m_rd   [DEPTH];
    logic [31:0]      m_val  [DEPTH];
    logic [31:0]      m_addr [DEPTH];
    bit               m_done [DEPTH];
    int               m_tail;
    bit               m_flush;
    logic [31:0]      m_rst_addr;

    always #5 clk_in = ~clk_in;

    rob_mc #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WB_PORTS(WB), .COMMIT_W(CW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .full(full),
        .free_id(free_id), .head_id(head_id), .flush(flush), .rst_addr(rst_addr),
        .dsp_valid(dsp_valid), .dsp_type(dsp_type), .dsp_rd(dsp_rd),
        .dsp_value(dsp_value), .dsp_addr(dsp_addr), .dsp_done(dsp_done),
        .qry_id(qry_id), .qry_ready(qry_ready), .qry_value(qry_value),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_value(cm_value),
        .dep_valid(dep_valid), .dep_rd(dep_rd), .dep_tag(dep_tag),
        .st_commit(st_commit), .st_ack(st_ack)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit t_reg(input logic [2:0] t);
        return (t == 3'd0) || (t == 3'd1);
    endfunction

    function automatic bit t_serial(input logic [2:0] t);
        return (t == 3'd2) || (t == 3'd3);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m_type[i] = '0; m_rd[i] = '0; m_val[i] = '0; m_addr[i] = '0; m_done[i] = 0;
        end
        m_tail = 0; m_flush = 0; m_rst_addr = '0;
    endfunction

    // Compare all outputs against the model for the current inputs, then advance the model.
    task automatic model_step();
        int cnt, n, hd, nx, acc, t;
        bit en, mis, e_full, e_st, e_dep;
        logic [1:0]  e_cmv, e_qr;
        logic [9:0]  e_rd, e_tag;
        logic [63:0] e_val, e_qv;
        cnt = exp_q.size();
        en  = rdy_in && !m_flush;
        hd  = (cnt > 0) ? int'(exp_q[0]) : m_tail;
        nx  = (cnt > 1) ? int'(exp_q[1]) : 0;
        n   = 0;
        if (en && cnt > 0 && m_done[hd] && (m_type[hd] != 3'd2 || st_ack)) n = 1;
        if (n == 1 && cnt > 1 && m_done[nx] && !t_serial(m_type[hd]) && !t_serial(m_type[nx])) n = 2;
        e_cmv = '0; e_rd = '0; e_tag = '0; e_val = '0;
        for (int s = 0; s < n; s++) begin
            t = (s == 0) ? hd : nx;
            if (t_reg(m_type[t])) begin
                e_cmv[s] = 1'b1;
                e_rd[s*5 +: 5]   = m_rd[t];
                e_tag[s*5 +: 5]  = 5'(t);
                e_val[s*32 +: 32] = m_val[t];
            end
        end
        mis    = (n > 0) && (m_type[hd] == 3'd3) && (m_val[hd][0] != m_rd[hd][0]);
        acc    = (en && dsp_valid && (cnt < DEPTH || n > 0)) ? 1 : 0;
        e_full = (cnt == DEPTH) || (cnt == DEPTH - 1 && dsp_valid && n == 0);
        e_st   = en && cnt > 0 && m_done[hd] && (m_type[hd] == 3'd2);
        e_dep  = (acc == 1) && t_reg(dsp_type);
        e_qr = '0; e_qv = '0;
        for (int q = 0; q < 2; q++) begin
            t = int'(qry_id[q*5 +: 5]);
            e_qr[q] = m_done[t];
            e_qv[q*32 +: 32] = m_val[t];
            for (int k = 0; k < WB; k++)
                if (en && wb_valid[k] && int'(wb_id[k*5 +: 5]) == t) begin
                    e_qr[q] = 1'b1; e_qv[q*32 +: 32] = wb_value[k*32 +: 32];
                end
            if (acc == 1 && t == m_tail) begin
                e_qr[q] = dsp_done; e_qv[q*32 +: 32] = dsp_value;
            end
        end
        check("full", 64'(full), 64'(e_full));
        check("free_id", 64'(free_id), 64'((m_tail + acc) % DEPTH));
        check("head_id", 64'(head_id), 64'((hd + n) % DEPTH));
        check("flush", 64'(flush), 64'(m_flush));
        check("rst_addr", 64'(rst_addr), 64'(m_rst_addr));
        check("cm_valid", 64'(cm_valid), 64'(e_cmv));
        check("cm_rd", 64'(cm_rd), 64'(e_rd));
        check("cm_tag", 64'(cm_tag), 64'(e_tag));
        check("cm_value", cm_value, e_val);
        check("st_commit", 64'(st_commit), 64'(e_st));
        check("dep_valid", 64'(dep_valid), 64'(e_dep));
        if (e_dep) begin
            check("dep_rd", 64'(dep_rd), 64'(dsp_rd));
            check("dep_tag", 64'(dep_tag), 64'(m_tail));
        end
        check("qry_ready", 64'(qry_ready), 64'(e_qr));
        check("qry_value", qry_value, e_qv);
        if (rdy_in) begin
            if (m_flush) begin
                exp_q.delete();
                m_tail = 0;
                for (int i = 0; i < DEPTH; i++) m_done[i] = 0;
                m_flush = 0;
            end else begin
                repeat (n) void'(exp_q.pop_front());
                if (mis) begin m_flush = 1; m_rst_addr = m_addr[hd]; end
                if (acc == 1) begin
                    m_type[m_tail] = dsp_type; m_rd[m_tail] = dsp_rd;
                    m_val[m_tail] = dsp_value; m_addr[m_tail] = dsp_addr;
                    m_done[m_tail] = dsp_done;
                    exp_q.push_back(5'(m_tail));
                    m_tail = (m_tail + 1) % DEPTH;
                end
                for (int k = 0; k < WB; k++)
                    if (wb_valid[k]) begin
                        m_done[int'(wb_id[k*5 +: 5])] = 1;
                        m_val[int'(wb_id[k*5 +: 5])]  = wb_value[k*32 +: 32];
                    end
            end
        end
    endtask

    task automatic idle();
        rdy_in = 1'b1; dsp_valid = 1'b0; dsp_type = '0; dsp_rd = '0;
        dsp_value = '0; dsp_addr = '0; dsp_done = 1'b0; qry_id = '0;
        wb_valid = '0; wb_id = '0; wb_value = '0; st_ack = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk_in);
        model_step();
    endtask

    task automatic advance();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        model_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic disp(input logic [2:0] ty, input logic [4:0] rd, input logic [31:0] val,
                        input logic [31:0] addr, input logic done);
        dsp_valid = 1'b1; dsp_type = ty; dsp_rd = rd;
        dsp_value = val; dsp_addr = addr; dsp_done = done;
    endtask

    task automatic drive_random();
        int cand[$];
        int j, r;
        rdy_in = ($urandom_range(0, 9) != 0);
        st_ack = ($urandom_range(0, 9) < 7);
        if (exp_q.size() < DEPTH && $urandom_range(0, 2) != 0) begin
            r = $urandom_range(0, 9);
            disp((r == 4) ? 3'd1 : (r == 5) ? 3'd2 : (r == 6) ? 3'd3 :
                 (r == 7) ? 3'd4 : (r == 8) ? 3'd5 : 3'd0,
                 5'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        foreach (exp_q[i]) if (!m_done[exp_q[i]]) cand.push_back(int'(exp_q[i]));
        for (int k = 0; k < WB; k++) begin
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, cand.size() - 1);
                wb_valid[k] = 1'b1;
                wb_id[k*5 +: 5] = 5'(cand[j]);
                wb_value[k*32 +: 32] = $urandom;
                cand.delete(j);
            end
        end
        if ($urandom_range(0, 1) == 1 && exp_q.size() > 0)
            qry_id = {exp_q[$urandom_range(0, exp_q.size() - 1)], 5'($urandom)};
        else
            qry_id = 10'($urandom);
    endtask

    initial begin
        rst_in = 1'b1;
        idle();
        model_reset();
        #12;

        // Reset state.
        do_reset();
        settle();
        check("rst_full", 64'(full), 64'd0);
        check("rst_free_id", 64'(free_id), 64'd0);
        check("rst_head_id", 64'(head_id), 64'd0);
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_cm_valid", 64'(cm_valid), 64'd0);
        check("rst_qry", 64'(qry_ready), 64'd0);
        advance();

        // Asynchronous reset in the middle of operation.
        for (int i = 0; i < 5; i++) begin
            disp(3'd0, 5'(i + 1), 32'(i), 32'd0, 1'b0);
            settle();
            advance();
        end
        #1;
        check("pre_rst_free_id", 64'(free_id), 64'd5);
        rst_in = 1'b1;
        #1;
        check("async_full", 64'(full), 64'd0);
        check("async_free_id", 64'(free_id), 64'd0);
        check("async_flush", 64'(flush), 64'd0);
        check("async_head_id", 64'(head_id), 64'd0);
        model_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Dual commit after both entries complete in one writeback cycle.
        disp(3'd0, 5'd1, 32'd0, 32'd0, 1'b0); settle(); advance();
        disp(3'd0, 5'd2, 32'd0, 32'd0, 1'b0); settle(); advance();
        wb_valid = 2'b11; wb_id = {5'd1, 5'd0}; wb_value = {32'd9, 32'd7};
        qry_id = {5'd1, 5'd0};
        settle();
        check("wb_qry_ready", 64'(qry_ready), 64'd3);
        check("wb_qry_value", qry_value, {32'd9, 32'd7});
        advance();
        settle();
        check("dual_cm_valid", 64'(cm_valid), 64'd3);
        check("dual_cm_rd", 64'(cm_rd), 64'({5'd2, 5'd1}));
        check("dual_cm_value", cm_value, {32'd9, 32'd7});
        check("dual_head_id", 64'(head_id), 64'd2);
        advance();

        // Bypass priority: dispatch beats writeback beats stored entry.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp(3'd0, 5'(i + 1), 32'd0, 32'd0, 1'b0); settle(); advance();
        end
        wb_valid = 2'b10; wb_id = {5'd3, 5'd0}; wb_value = {32'hDEAD, 32'd0};
        disp(3'd0, 5'd9, 32'h55, 32'd0, 1'b1);
        qry_id = {5'd3, 5'd4};
        settle();
        check("byp_ready", 64'(qry_ready), 64'd3);
        check("byp_value", qry_value, {32'h0000DEAD, 32'h00000055});
        advance();
        qry_id = {5'd2, 5'd3};
        settle();
        check("stored_ready", 64'(qry_ready), 64'd1);
        advance();

        // Store handshake.
        do_reset();
        disp(3'd2, 5'd0, 32'd0, 32'd0, 1'b1); settle(); advance();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("st_wait_commit", 64'(st_commit), 64'd1);
            check("st_wait_head", 64'(head_id), 64'd0);
            advance();
        end
        st_ack = 1'b1;
        settle();
        check("st_ack_head", 64'(head_id), 64'd1);
        check("st_ack_cm_valid", 64'(cm_valid), 64'd0);
        advance();
        settle();
        check("st_done_commit", 64'(st_commit), 64'd0);
        advance();

        // Branch mispredict and flush.
        do_reset();
        disp(3'd3, 5'd1, 32'd0, 32'h100, 1'b0); settle(); advance();
        wb_valid = 2'b01; wb_id = {5'd0, 5'd0}; wb_value = 64'd0;
        settle(); advance();
        settle();
        check("br_commit_flush", 64'(flush), 64'd0);
        advance();
        disp(3'd0, 5'd4, 32'd1, 32'd0, 1'b1);
        settle();
        check("br_flush", 64'(flush), 64'd1);
        check("br_rst_addr", 64'(rst_addr), 64'h100);
        check("br_flush_dep", 64'(dep_valid), 64'd0);
        check("br_flush_free", 64'(free_id), 64'd1);
        advance();
        settle();
        check("post_flush", 64'(flush), 64'd0);
        check("post_flush_free", 64'(free_id), 64'd0);
        check("post_flush_head", 64'(head_id), 64'd0);
        advance();

        // Fill to capacity, then retire one while dispatching into the wrapped tail.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            disp(3'd0, 5'(i % 31 + 1), 32'(i), 32'd0, 1'b0);
            settle();
            if (i == 30) check("fill_full_30", 64'(full), 64'd0);
            if (i == 31) check("fill_full_31", 64'(full), 64'd1);
            advance();
        end
        settle();
        check("fill_full", 64'(full), 64'd1);
        check("fill_free_id", 64'(free_id), 64'd0);
        advance();
        wb_valid = 2'b01; wb_id = {5'd0, 5'd0}; wb_value = {32'd0, 32'h77};
        settle(); advance();
        disp(3'd0, 5'd7, 32'd5, 32'd0, 1'b0);
        settle();
        check("wrap_cm_valid", 64'(cm_valid), 64'd1);
        check("wrap_free_id", 64'(free_id), 64'd1);
        check("wrap_dep_tag", 64'(dep_tag), 64'd0);
        check("wrap_head_id", 64'(head_id), 64'd1);
        advance();
        settle();
        check("wrap_full", 64'(full), 64'd1);
        advance();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
